// File: rtl/weightmem_reader_pkg.sv
// Bank sizing constants and the reader FSM state type.
// cutie_params carries the shared sizing that the reader's parameter defaults come from.
package cutie_params;
    localparam int unsigned N_I             = 96;
    localparam int unsigned WEIGHT_STAGGER  = 8;
    localparam int unsigned WEIGHTBANKDEPTH = 1024;
endpackage

package enums_weightmem;
    typedef enum logic [1:0] {
        WR_IDLE,
        WR_READ,
        WR_DRAIN
    } weightmem_reader_state_e;
endpackage

// File: rtl/weightmem_reader_fifo.sv
// Synchronous FIFO of {last, data} entries with occupancy output and flush.
// Storage resets to zero so the head reads 0 straight out of reset.
module weightmem_reader_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       push_last_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       last_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH:0]    mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : PtrW'(ptr + 1'b1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign last_o  = mem_q[rd_ptr_q][WIDTH];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end
endmodule

// File: rtl/weightmem_reader.sv
// Streams a contiguous, wrapping range of words out of one weight bank onto a valid/ready
// stream, absorbing the bank's one-cycle read latency through a small output FIFO.
module weightmem_reader #(
    parameter int unsigned NUM_WORDS  = cutie_params::WEIGHTBANKDEPTH,
    parameter int unsigned DATA_WIDTH =
        ((cutie_params::N_I / cutie_params::WEIGHT_STAGGER + 4) / 5) * 8,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic [$clog2(NUM_WORDS)-1:0]   base_addr_i,
    input  logic [$clog2(NUM_WORDS):0]     num_words_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [$clog2(NUM_WORDS)-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [DATA_WIDTH-1:0]          mem_be_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           last_o
);
    import enums_weightmem::*;

    localparam int unsigned AW   = $clog2(NUM_WORDS);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    weightmem_reader_state_e state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic            inflight_q, last_inflight_q;
    logic            done_q, done_d;
    logic [CntW-1:0] fifo_count;
    logic            room;

    // Credit check uses registered state only, so ready_i never reaches the bank port.
    assign room = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        mem_req_o   = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (start_i) begin
                    if (num_words_i != '0) begin
                        state_d     = WR_READ;
                        addr_d      = base_addr_i;
                        remaining_d = num_words_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WR_READ: begin
                if (room) begin
                    mem_req_o   = 1'b1;
                    addr_d      = (addr_q == AW'(NUM_WORDS - 1)) ? '0 : AW'(addr_q + 1'b1);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) begin
                        state_d = WR_DRAIN;
                    end
                end
            end
            WR_DRAIN: begin
                if (valid_o && ready_i && last_o) begin
                    state_d = WR_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = WR_IDLE;
        endcase
        if (clear_i) begin
            state_d = WR_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= WR_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= mem_req_o && !clear_i;
            last_inflight_q <= mem_req_o && (remaining_q == CW'(1));
            done_q          <= done_d;
        end
    end

    assign busy_o      = (state_q != WR_IDLE);
    assign done_o      = done_q;
    assign mem_we_o    = 1'b0;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = '0;
    assign mem_be_o    = '0;

    weightmem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (clear_i),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata_i),
        .push_last_i (last_inflight_q),
        .pop_i       (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .valid_o     (valid_o),
        .count_o     (fifo_count)
    );
endmodule

// File: tb/tb_weightmem_reader.sv
// Self-checking bench for weightmem_reader: directed timing checks plus a queue-based
// reference model of the expected address and word streams.
module tb_weightmem_reader;
    localparam int unsigned NW = 40;
    localparam int unsigned DW = 24;
    localparam int unsigned FD = 3;
    localparam int unsigned AW = $clog2(NW);
    localparam int unsigned CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst, start_i, clear_i, ready_i;
    logic [AW-1:0] base_addr_i, mem_addr_o;
    logic [CW-1:0] num_words_i;
    logic          busy_o, done_o, mem_req_o, mem_we_o, valid_o, last_o;
    logic [DW-1:0] mem_wdata_o, mem_be_o, mem_rdata_i, data_o;

    always #5 clk = ~clk;

    weightmem_reader #(
        .NUM_WORDS  (NW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .base_addr_i (base_addr_i),
        .num_words_i (num_words_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o)
    );

    // Bank model: data only the cycle after a request, garbage otherwise.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
        else           mem_rdata_i <= DW'($urandom) | DW'(24'h800000);
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    bit            mon_on = 1'b0;
    int            outstanding = 0;
    logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_req_o) begin
                chk("room", 32'(outstanding < int'(FD)), 32'd1);
                chk("req_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) chk("addr", 32'(mem_addr_o), 32'(exp_addr.pop_front()));
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_data", 32'(data_o), 32'(prev_data));
                chk("stall_last", 32'(last_o), 32'(prev_last));
            end
            if (valid_o && ready_i) begin
                chk("word_expected", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0) begin
                    chk("data", 32'(data_o), 32'(exp_data.pop_front()));
                    chk("last", 32'(last_o), 32'(exp_data.size() == 0));
                end
            end
            outstanding = outstanding + int'(mem_req_o) - int'(valid_o && ready_i);
            prev_valid  = valid_o;
            prev_ready  = ready_i;
            prev_data   = data_o;
            prev_last   = last_o;
        end else begin
            outstanding = 0;
            prev_valid  = 1'b0;
        end
    end

    // Enter and leave at posedge+1; loads the expected streams, then waits for done_o.
    task automatic run_cmd(input int base, input int num, input bit rnd, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < num; i++) begin
            logic [AW-1:0] a = AW'((base + i) % int'(NW));
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        num_words_i = CW'(num);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = DW'($urandom);
        rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
        base_addr_i = '0; num_words_i = '0;
        #2;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Cycle-exact: base 5, count 4, ready held high.
        for (int c = 0; c < 9; c++) begin
            start_i     = (c == 0);
            base_addr_i = AW'(5);
            num_words_i = CW'(4);
            @(negedge clk);
            chk("t1_req", 32'(mem_req_o), 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk("t1_addr", 32'(mem_addr_o), 32'(5 + c - 1));
            chk("t1_valid", 32'(valid_o), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk("t1_data", 32'(data_o), 32'(mem[5 + c - 3]));
                chk("t1_last", 32'(last_o), 32'(c == 6));
            end
            chk("t1_done", 32'(done_o), 32'(c == 7));
            chk("t1_busy", 32'(busy_o), 32'(c >= 1 && c <= 6));
            @(posedge clk); #1;
        end

        // Wrap past the top of a non-power-of-two bank.
        mon_on = 1'b1;
        run_cmd(38, 4, 1'b0, "wrap");

        // Ramp under random backpressure.
        foreach (mem[i]) mem[i] = DW'(i);
        run_cmd(int'($urandom_range(0, NW - 1)), 32, 1'b1, "ramp");
        mon_on = 1'b0;

        // Count zero.
        for (int c = 0; c < 3; c++) begin
            start_i     = (c == 0);
            base_addr_i = AW'(9);
            num_words_i = '0;
            @(negedge clk);
            chk("z_req", 32'(mem_req_o), 32'd0);
            chk("z_done", 32'(done_o), 32'(c == 1));
            chk("z_busy", 32'(busy_o), 32'd0);
            @(posedge clk); #1;
        end

        // Clear in cycle 3 of a count-8 read.
        foreach (mem[i]) mem[i] = DW'($urandom);
        for (int c = 0; c < 4; c++) begin
            start_i     = (c == 0);
            clear_i     = (c == 3);
            base_addr_i = AW'(10);
            num_words_i = CW'(8);
            @(negedge clk);
            chk("clr_done_pre", 32'(done_o), 32'd0);
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        clear_i = 1'b0;
        chk("clr_valid", 32'(valid_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_done", 32'(done_o), 32'd0);
        mon_on = 1'b1;
        run_cmd(0, 2, 1'b0, "after_clr");
        mon_on = 1'b0;

        // Asynchronous reset mid-read with the FIFO backed up.
        start_i     = 1'b1;
        base_addr_i = AW'(0);
        num_words_i = CW'(8);
        ready_i     = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        #2;
        rst     = 1'b1;
        start_i = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_req", 32'(mem_req_o), 32'd0);
        chk("arst_data", 32'(data_o), 32'd0);
        chk("arst_last", 32'(last_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(valid_o), 32'd0);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        ready_i = 1'b1;
        mon_on  = 1'b1;
        run_cmd(7, 3, 1'b0, "after_rst");
        mon_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
